// File: rtl/frame_buffer_manager.sv
// -----------------------------------------------------------------------------
// frame_buffer_manager
//
// Latest-frame arbiter over NUM_BUFS DDR frame buffers, shared between the
// camera-side AXI4 writer and the HDMI-side AXI4 reader. It lives entirely in
// the 100 MHz AXI clock domain.
//
// Every buffer is in exactly one of four states: FREE, WRITING, READY or
// READING. At most one buffer holds each of the last three states at a time.
// The writer always gets a fresh buffer. A completed frame replaces any older
// unread one, which is reported as dropped. The reader always takes the newest
// completed frame. If no new frame is waiting, the reader re-reads its current
// buffer, which is reported as repeated.
//
// Events in one cycle are applied in this order: wr_frame_done, then
// rd_frame_start, then wr_frame_start. All outputs are registered, so an event
// at cycle n is visible on the outputs at cycle n+1.
//
// Optional build macro:
//   FB_STATS_EN  - when defined, stat_written / stat_dropped / stat_repeated
//                  are saturating 16-bit event counters. When undefined, they
//                  are tied to zero and no counter logic is built.
//
// Ports:
//   clk             rising-edge clock (clk_100Mhz domain)
//   rst             synchronous, active-high reset
//   wr_frame_start  1-cycle pulse: writer begins a frame
//   wr_frame_done   1-cycle pulse: writer's last burst response received
//   rd_frame_start  1-cycle pulse: reader begins a frame
//   wr_base_addr    base address the writer must use
//   rd_base_addr    base address the reader must use
//   wr_idx          buffer index being written
//   rd_idx          buffer index being read
//   rd_valid        sticky: a completed frame has reached the reader
//   frame_dropped   1-cycle pulse: an unread completed frame was discarded
//   frame_repeated  1-cycle pulse: the reader re-reads its previous frame
//   stat_written    count of accepted wr_frame_done events
//   stat_dropped    count of frame_dropped pulses
//   stat_repeated   count of frame_repeated pulses
// -----------------------------------------------------------------------------
module frame_buffer_manager #(
    parameter int                NUM_BUFS     = 3,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 32'h0009_6000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic [ADDR_W-1:0] rd_base_addr,
    output logic [2:0]        wr_idx,
    output logic [2:0]        rd_idx,
    output logic              rd_valid,
    output logic              frame_dropped,
    output logic              frame_repeated,
    output logic [15:0]       stat_written,
    output logic [15:0]       stat_dropped,
    output logic [15:0]       stat_repeated
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } buf_state_t;

    typedef buf_state_t [NUM_BUFS-1:0] buf_vec_t;

    // Returns {found, index} of the lowest-index buffer in state 'want'.
    function automatic logic [3:0] find_buf(input buf_vec_t s, input buf_state_t want);
        logic [3:0] res;
        res = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (s[i] == want) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    // Returns 's' with buffer 'idx' moved to state 'val'.
    function automatic buf_vec_t set_buf(input buf_vec_t s, input logic [2:0] idx,
                                         input buf_state_t val);
        buf_vec_t res;
        res = s;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (3'(i) == idx) res[i] = val;
        end
        return res;
    endfunction

    buf_vec_t   st;
    buf_vec_t   nxt_st;
    logic [2:0] nxt_wr_idx;
    logic [2:0] nxt_rd_idx;
    logic       nxt_rd_valid;
    logic       nxt_dropped;
    logic       nxt_repeated;
    logic       done_acc;

    // {found, index} results of the buffer searches below.
    logic [3:0] wr_hit;       // buffer WRITING before any event
    logic [3:0] done_rdy_hit; // older READY frame that a completion displaces
    logic [3:0] rd_rdy_hit;   // READY frame offered to the reader
    logic [3:0] rdg_hit;      // buffer the reader is releasing
    logic [3:0] busy_hit;     // writer already busy (aborted frame restarts)
    logic [3:0] free_hit;     // lowest FREE buffer for a new frame
    logic [3:0] steal_hit;    // READY buffer taken when nothing is FREE

    // NOTE: every signal driven here gets its default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        nxt_st       = st;
        nxt_wr_idx   = wr_idx;
        nxt_rd_idx   = rd_idx;
        nxt_rd_valid = rd_valid;
        nxt_dropped  = 1'b0;
        nxt_repeated = 1'b0;
        done_acc     = 1'b0;
        done_rdy_hit = '0;
        rd_rdy_hit   = '0;
        rdg_hit      = '0;
        busy_hit     = '0;
        free_hit     = '0;
        steal_hit    = '0;

        wr_hit = find_buf(st, WRITING);

        // 1) Completion: the new frame replaces any unread older one.
        if (wr_frame_done && wr_hit[3]) begin
            done_rdy_hit = find_buf(st, READY);
            if (done_rdy_hit[3]) begin
                nxt_st      = set_buf(nxt_st, done_rdy_hit[2:0], FREE);
                nxt_dropped = 1'b1;
            end
            nxt_st   = set_buf(nxt_st, wr_hit[2:0], READY);
            done_acc = 1'b1;
        end

        // 2) Reader: take the newest frame, including one completed this cycle.
        if (rd_frame_start) begin
            rd_rdy_hit = find_buf(nxt_st, READY);
            if (rd_rdy_hit[3]) begin
                rdg_hit = find_buf(nxt_st, READING);
                if (rdg_hit[3]) nxt_st = set_buf(nxt_st, rdg_hit[2:0], FREE);
                nxt_st       = set_buf(nxt_st, rd_rdy_hit[2:0], READING);
                nxt_rd_idx   = rd_rdy_hit[2:0];
                nxt_rd_valid = 1'b1;
            end else if (rd_valid) begin
                nxt_repeated = 1'b1;
            end
        end

        // 3) Writer: an aborted frame keeps its buffer; otherwise pick a new one.
        // With only two buffers there may be no FREE one, so the unread frame
        // is sacrificed.
        if (wr_frame_start) begin
            busy_hit = find_buf(nxt_st, WRITING);
            if (!busy_hit[3]) begin
                free_hit = find_buf(nxt_st, FREE);
                if (free_hit[3]) begin
                    nxt_st     = set_buf(nxt_st, free_hit[2:0], WRITING);
                    nxt_wr_idx = free_hit[2:0];
                end else begin
                    steal_hit = find_buf(nxt_st, READY);
                    if (steal_hit[3]) begin
                        nxt_st      = set_buf(nxt_st, steal_hit[2:0], WRITING);
                        nxt_wr_idx  = steal_hit[2:0];
                        nxt_dropped = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-buffer state vector is a handful of flops and is
            // reset explicitly, because its reset value is functionally
            // required (buffer 0 starts out owned by the reader).
            for (int i = 0; i < NUM_BUFS; i++) st[i] <= FREE;
            st[0]          <= READING;
            wr_idx         <= 3'd1;
            rd_idx         <= 3'd0;
            rd_valid       <= 1'b0;
            frame_dropped  <= 1'b0;
            frame_repeated <= 1'b0;
            wr_base_addr   <= BASE_ADDR + FRAME_STRIDE;
            rd_base_addr   <= BASE_ADDR;
        end else begin
            st             <= nxt_st;
            wr_idx         <= nxt_wr_idx;
            rd_idx         <= nxt_rd_idx;
            rd_valid       <= nxt_rd_valid;
            frame_dropped  <= nxt_dropped;
            frame_repeated <= nxt_repeated;
            // Bases only move with their index, so the multiplier result is
            // captured only on a change.
            if (nxt_wr_idx != wr_idx)
                wr_base_addr <= BASE_ADDR + ADDR_W'(nxt_wr_idx) * FRAME_STRIDE;
            if (nxt_rd_idx != rd_idx)
                rd_base_addr <= BASE_ADDR + ADDR_W'(nxt_rd_idx) * FRAME_STRIDE;
        end
    end

`ifdef FB_STATS_EN
    logic [15:0] cnt_written;
    logic [15:0] cnt_dropped;
    logic [15:0] cnt_repeated;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_written  <= '0;
            cnt_dropped  <= '0;
            cnt_repeated <= '0;
        end else begin
            if (done_acc && cnt_written != 16'hFFFF)      cnt_written  <= cnt_written + 16'd1;
            if (nxt_dropped && cnt_dropped != 16'hFFFF)   cnt_dropped  <= cnt_dropped + 16'd1;
            if (nxt_repeated && cnt_repeated != 16'hFFFF) cnt_repeated <= cnt_repeated + 16'd1;
        end
    end

    assign stat_written  = cnt_written;
    assign stat_dropped  = cnt_dropped;
    assign stat_repeated = cnt_repeated;
`else
    logic unused_done_acc;
    assign unused_done_acc = done_acc;
    assign stat_written    = '0;
    assign stat_dropped    = '0;
    assign stat_repeated   = '0;
`endif

    // The reader and the writer must never share a buffer.
    assert property (@(posedge clk) disable iff (rst)
        !(wr_hit[3] && wr_hit[2:0] == rd_idx))
        else $error("reader and writer share buffer %0d", rd_idx);

endmodule

// File: tb/tb_frame_buffer_manager.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_manager
//
// Drives two instances from one stimulus stream: one with three buffers and
// one with two. Each instance is checked every cycle against a reference model.
// The model tracks only three facts per instance: which buffer the reader
// holds, which buffer holds an unread frame, and which buffer the writer
// holds. Every other buffer is free.
// -----------------------------------------------------------------------------
module tb_frame_buffer_manager;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0009_6000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_frame_start = 1'b0;
    logic wr_frame_done  = 1'b0;
    logic rd_frame_start = 1'b0;

    logic [31:0] wr_base_3, rd_base_3, wr_base_2, rd_base_2;
    logic [2:0]  wr_idx_3, rd_idx_3, wr_idx_2, rd_idx_2;
    logic        rd_valid_3, dropped_3, repeated_3;
    logic        rd_valid_2, dropped_2, repeated_2;
    logic [15:0] sw_3, sd_3, sr_3, sw_2, sd_2, sr_2;

    always #5 clk = ~clk;

    frame_buffer_manager #(.NUM_BUFS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
        .rd_frame_start(rd_frame_start),
        .wr_base_addr(wr_base_3), .rd_base_addr(rd_base_3),
        .wr_idx(wr_idx_3), .rd_idx(rd_idx_3), .rd_valid(rd_valid_3),
        .frame_dropped(dropped_3), .frame_repeated(repeated_3),
        .stat_written(sw_3), .stat_dropped(sd_3), .stat_repeated(sr_3)
    );

    frame_buffer_manager #(.NUM_BUFS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
        .rd_frame_start(rd_frame_start),
        .wr_base_addr(wr_base_2), .rd_base_addr(rd_base_2),
        .wr_idx(wr_idx_2), .rd_idx(rd_idx_2), .rd_valid(rd_valid_2),
        .frame_dropped(dropped_2), .frame_repeated(repeated_2),
        .stat_written(sw_2), .stat_dropped(sd_2), .stat_repeated(sr_2)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model, index 0 -> three buffers, index 1 -> two buffers.
    // -1 means "no such buffer".
    int nb[2] = '{3, 2};
    int m_rd[2], m_ready[2], m_wr[2], m_wridx[2];
    bit m_valid[2], m_drop[2], m_rep[2];
    int m_sw[2], m_sd[2], m_sr[2];

    function automatic logic [31:0] base_of(input int idx);
        return BASE + 32'(idx) * STRIDE;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_step(input int k, input bit r, input bit d, input bit rs, input bit ws);
        int pick;
        if (r) begin
            m_rd[k] = 0; m_ready[k] = -1; m_wr[k] = -1; m_wridx[k] = 1;
            m_valid[k] = 0; m_drop[k] = 0; m_rep[k] = 0;
            m_sw[k] = 0; m_sd[k] = 0; m_sr[k] = 0;
            return;
        end
        m_drop[k] = 0;
        m_rep[k]  = 0;
        if (d && m_wr[k] >= 0) begin
            if (m_ready[k] >= 0) m_drop[k] = 1;
            m_ready[k] = m_wr[k];
            m_wr[k]    = -1;
            m_sw[k]    = sat_inc(m_sw[k]);
        end
        if (rs) begin
            if (m_ready[k] >= 0) begin
                m_rd[k]    = m_ready[k];
                m_ready[k] = -1;
                m_valid[k] = 1;
            end else if (m_valid[k]) begin
                m_rep[k] = 1;
            end
        end
        if (ws && m_wr[k] < 0) begin
            pick = -1;
            for (int i = nb[k] - 1; i >= 0; i--)
                if (i != m_rd[k] && i != m_ready[k]) pick = i;
            if (pick < 0) begin
                pick       = m_ready[k];
                m_ready[k] = -1;
                m_drop[k]  = 1;
            end
            m_wr[k]    = pick;
            m_wridx[k] = pick;
        end
        if (m_drop[k]) m_sd[k] = sat_inc(m_sd[k]);
        if (m_rep[k])  m_sr[k] = sat_inc(m_sr[k]);
    endtask

    task automatic check_inst(input int k, input string ph,
                              input logic [2:0] wi, input logic [2:0] ri,
                              input logic [31:0] wb, input logic [31:0] rb,
                              input logic v, input logic fd, input logic fr,
                              input logic [15:0] sw, input logic [15:0] sd,
                              input logic [15:0] sr);
        string p;
        int e_sw, e_sd, e_sr;
        p = $sformatf("%s n=%0d", ph, nb[k]);
`ifdef FB_STATS_EN
        e_sw = m_sw[k]; e_sd = m_sd[k]; e_sr = m_sr[k];
`else
        e_sw = 0; e_sd = 0; e_sr = 0;
`endif
        check({p, " wr_idx"},         32'(wi), 32'(m_wridx[k]));
        check({p, " rd_idx"},         32'(ri), 32'(m_rd[k]));
        check({p, " wr_base"},        wb, base_of(m_wridx[k]));
        check({p, " rd_base"},        rb, base_of(m_rd[k]));
        check({p, " rd_valid"},       32'(v), 32'(m_valid[k]));
        check({p, " frame_dropped"},  32'(fd), 32'(m_drop[k]));
        check({p, " frame_repeated"}, 32'(fr), 32'(m_rep[k]));
        check({p, " stat_written"},   32'(sw), 32'(e_sw));
        check({p, " stat_dropped"},   32'(sd), 32'(e_sd));
        check({p, " stat_repeated"},  32'(sr), 32'(e_sr));
    endtask

    // One clock cycle: apply events, let the edge pass, then compare both
    // instances against the model.
    task automatic cycle(input string ph, input bit r, input bit d, input bit rs, input bit ws);
        rst            = r;
        wr_frame_done  = d;
        rd_frame_start = rs;
        wr_frame_start = ws;
        @(posedge clk);
        #1;
        rst = 0; wr_frame_done = 0; rd_frame_start = 0; wr_frame_start = 0;
        model_step(0, r, d, rs, ws);
        model_step(1, r, d, rs, ws);
        check_inst(0, ph, wr_idx_3, rd_idx_3, wr_base_3, rd_base_3, rd_valid_3,
                   dropped_3, repeated_3, sw_3, sd_3, sr_3);
        check_inst(1, ph, wr_idx_2, rd_idx_2, wr_base_2, rd_base_2, rd_valid_2,
                   dropped_2, repeated_2, sw_2, sd_2, sr_2);
    endtask

    initial begin
        // Reset state.
        cycle("reset", 1, 0, 0, 0);
        cycle("reset", 1, 0, 0, 0);
        cycle("idle", 0, 0, 0, 0);

        // First frame written then read.
        cycle("p1 wstart", 0, 0, 0, 1);
        cycle("p1 wdone",  0, 1, 0, 0);
        cycle("p1 rstart", 0, 0, 1, 0);

        // Write, complete, start again: on two buffers this takes the READY one.
        cycle("p3 wstart", 0, 0, 0, 1);
        cycle("p3 wdone",  0, 1, 0, 0);
        cycle("p3 wstart", 0, 0, 0, 1);
        cycle("p3 wdone",  0, 1, 0, 0);
        cycle("p2 rstart", 0, 0, 1, 0);

        // Two complete frames with no read: the newer one survives.
        cycle("p2 wstart", 0, 0, 0, 1);
        cycle("p2 wdone",  0, 1, 0, 0);
        cycle("p2 wstart", 0, 0, 0, 1);
        cycle("p2 wdone",  0, 1, 0, 0);
        cycle("p2 rstart", 0, 0, 1, 0);

        // Completion and read start in the same cycle.
        cycle("p4 wstart",  0, 0, 0, 1);
        cycle("p4 done+rd", 0, 1, 1, 0);

        // Aborted frame: a restart keeps the same buffer.
        cycle("abort ws", 0, 0, 0, 1);
        cycle("abort ws", 0, 0, 0, 1);
        cycle("abort wd", 0, 1, 0, 0);

        // All three events in one cycle.
        cycle("all3 ws", 0, 0, 0, 1);
        cycle("all3",    0, 1, 1, 1);
        cycle("all3 wd", 0, 1, 0, 0);

        // Repeated frames.
        cycle("p5 rstart", 0, 0, 1, 0);
        cycle("p5 rstart", 0, 0, 1, 0);
        cycle("p5 rstart", 0, 0, 1, 0);

        // Reset mid-frame, then a stray completion.
        cycle("p6 wstart", 0, 0, 0, 1);
        cycle("p6 rst",    1, 0, 0, 0);
        cycle("p6 wdone",  0, 1, 0, 0);
        cycle("p6 rstart", 0, 0, 1, 0);

        // Read start before any frame exists: no repeat pulse.
        cycle("pre-valid rs", 0, 0, 1, 0);

        // Randomised traffic, with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            cycle("rand",
                  ($urandom_range(99) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
